// File: rtl/sb_ctrl_pkg.sv
// Shared types and fixed-point helpers for the SB iteration controller.
package sb_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_MVM_ISSUE = 4'd1,
    S_MVM_WAIT  = 4'd2,
    S_UPD_ISSUE = 4'd3,
    S_UPD_WAIT  = 4'd4,
    S_BC_ISSUE  = 4'd5,
    S_BC_WAIT   = 4'd6,
    S_STEP      = 4'd7,
    S_DONE      = 4'd8
  } sb_state_e;

  // Fixed-point 1.0 for a given number of fractional bits.
  function automatic logic [63:0] fx_one(input int unsigned frac_width);
    return 64'd1 << frac_width;
  endfunction

  // Unsigned add clamped to the largest value representable in 'width' bits.
  function automatic logic [63:0] sat_add_u(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned width);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/sb_iteration_controller_popcount.sv
// Combinational population count of the per-oscillator collision flags.
module sb_popcount #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]           mask,
  output logic [$clog2(N+1)-1:0] count_c
);

  localparam int unsigned PW = $clog2(N + 1);

  // Sum of set bits.
  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      count_c = count_c + PW'(mask[i]);
    end
  end

endmodule

// File: rtl/sb_iteration_controller.sv
// Sequences one SB time step per iteration (J*x, x/y update, wall check,
// write-back), ramps the pump amplitude and tallies wall collisions.
module sb_iteration_controller
  import sb_ctrl_pkg::*;
#(
  parameter int unsigned N              = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FRAC_WIDTH     = 16,
  parameter int unsigned ITER_WIDTH     = 16,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ITER_WIDTH-1:0] num_iter,
  input  logic [DATA_WIDTH-1:0] pump_step,
  input  logic [DATA_WIDTH-1:0] pump_max,
  output logic                  mvm_start,
  input  logic                  mvm_valid,
  output logic                  upd_start,
  input  logic                  upd_valid,
  output logic                  bc_valid_in,
  input  logic                  bc_valid_out,
  input  logic [N-1:0]          collision_mask,
  output logic                  state_we,
  output logic [DATA_WIDTH-1:0] pump_amp,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic [CNT_WIDTH-1:0]  total_collisions,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  aborted
);

  localparam int unsigned PW  = $clog2(N + 1);
  localparam int unsigned WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  // The pump format needs at least one integer bit to hold 1.0.
  if (FRAC_WIDTH >= DATA_WIDTH) begin : g_frac_range_bad
    $error("FRAC_WIDTH must be smaller than DATA_WIDTH");
  end

  sb_state_e state_q, state_d;

  logic [ITER_WIDTH-1:0] num_iter_q;
  logic [DATA_WIDTH-1:0] pump_step_q;
  logic [DATA_WIDTH-1:0] pump_max_q;
  logic [WDW-1:0]        wd_q;
  logic [PW-1:0]         pop_c;
  logic [DATA_WIDTH:0]   pump_sum_c;
  logic [DATA_WIDTH-1:0] pump_next_c;

  logic accept_c, in_wait_c, wd_exp_c, abort_hit_c;
  logic count_c, step_c, timeout_c, last_iter_c;

  sb_popcount #(.N(N)) u_popcount (
    .mask    (collision_mask),
    .count_c (pop_c)
  );

  // Next pump amplitude: carry or overshoot clamps to the captured maximum.
  always_comb begin
    pump_sum_c  = {1'b0, pump_amp} + {1'b0, pump_step_q};
    pump_next_c = pump_sum_c[DATA_WIDTH-1:0];
    if (pump_sum_c[DATA_WIDTH] || (pump_sum_c[DATA_WIDTH-1:0] > pump_max_q)) begin
      pump_next_c = pump_max_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; abort overrides any valid or watchdog expiry.
  always_comb begin
    state_d     = state_q;
    accept_c    = 1'b0;
    count_c     = 1'b0;
    step_c      = 1'b0;
    timeout_c   = 1'b0;
    in_wait_c   = (state_q == S_MVM_WAIT) || (state_q == S_UPD_WAIT) ||
                  (state_q == S_BC_WAIT);
    wd_exp_c    = in_wait_c && (wd_q == WD_LAST);
    abort_hit_c = abort && (state_q != S_IDLE) && (state_q != S_DONE);
    last_iter_c = (ITER_WIDTH'(iter_count + ITER_WIDTH'(1)) == num_iter_q);

    if (abort_hit_c) begin
      state_d = S_DONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            accept_c = 1'b1;
            state_d  = (num_iter == '0) ? S_DONE : S_MVM_ISSUE;
          end
        end
        S_MVM_ISSUE: state_d = S_MVM_WAIT;
        S_MVM_WAIT: begin
          if (mvm_valid)     state_d = S_UPD_ISSUE;
          else if (wd_exp_c) begin timeout_c = 1'b1; state_d = S_DONE; end
        end
        S_UPD_ISSUE: state_d = S_UPD_WAIT;
        S_UPD_WAIT: begin
          if (upd_valid)     state_d = S_BC_ISSUE;
          else if (wd_exp_c) begin timeout_c = 1'b1; state_d = S_DONE; end
        end
        S_BC_ISSUE: state_d = S_BC_WAIT;
        S_BC_WAIT: begin
          if (bc_valid_out) begin
            count_c = 1'b1;
            state_d = S_STEP;
          end else if (wd_exp_c) begin
            timeout_c = 1'b1;
            state_d   = S_DONE;
          end
        end
        S_STEP: begin
          step_c  = 1'b1;
          state_d = last_iter_c ? S_DONE : S_MVM_ISSUE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Watchdog: counts cycles spent in the current WAIT state, zero elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 wd_q <= '0;
    else if (in_wait_c && (state_d == state_q)) wd_q <= wd_q + WDW'(1);
    else                                        wd_q <= '0;
  end

  // Run configuration captured when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_iter_q  <= '0;
      pump_step_q <= '0;
      pump_max_q  <= '0;
    end else if (accept_c) begin
      num_iter_q  <= num_iter;
      pump_step_q <= pump_step;
      pump_max_q  <= pump_max;
    end
  end

  // Run statistics and sticky status; cleared on start, held in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pump_amp         <= '0;
      iter_count       <= '0;
      total_collisions <= '0;
      error            <= 1'b0;
      aborted          <= 1'b0;
    end else begin
      if (accept_c) begin
        pump_amp         <= '0;
        iter_count       <= '0;
        total_collisions <= '0;
        error            <= 1'b0;
        aborted          <= 1'b0;
      end
      if (step_c && !abort_hit_c) begin
        iter_count <= iter_count + ITER_WIDTH'(1);
        pump_amp   <= pump_next_c;
      end
      if (count_c) begin
        total_collisions <= CNT_WIDTH'(sat_add_u(64'(total_collisions), 64'(pop_c), CNT_WIDTH));
      end
      if (timeout_c)   error   <= 1'b1;
      if (abort_hit_c) aborted <= 1'b1;
    end
  end

  // Strobes decoded from the next state so they align with the state they name.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mvm_start   <= 1'b0;
      upd_start   <= 1'b0;
      bc_valid_in <= 1'b0;
      state_we    <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      mvm_start   <= (state_d == S_MVM_ISSUE);
      upd_start   <= (state_d == S_UPD_ISSUE);
      bc_valid_in <= (state_d == S_BC_ISSUE);
      state_we    <= (state_d == S_STEP);
      done        <= (state_d == S_DONE);
      busy        <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_sb_iteration_controller.sv
// Directed bench for the SB iteration controller.
module tb_sb_iteration_controller;
  import sb_ctrl_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 16;
  localparam int unsigned CW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [IW-1:0] num_iter = '0;
  logic [DW-1:0] pump_step = '0;
  logic [DW-1:0] pump_max = '0;
  logic          mvm_start, upd_start, bc_valid_in, state_we;
  logic          mvm_valid = 1'b0;
  logic          upd_valid = 1'b0;
  logic          bc_valid_out = 1'b0;
  logic [N-1:0]  collision_mask = '0;
  logic [DW-1:0] pump_amp;
  logic [IW-1:0] iter_count;
  logic [CW-1:0] total_collisions;
  logic          busy, done, error, aborted;

  sb_iteration_controller #(
    .N(N), .DATA_WIDTH(DW), .FRAC_WIDTH(16), .ITER_WIDTH(IW),
    .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_iter(num_iter), .pump_step(pump_step), .pump_max(pump_max),
    .mvm_start(mvm_start), .mvm_valid(mvm_valid),
    .upd_start(upd_start), .upd_valid(upd_valid),
    .bc_valid_in(bc_valid_in), .bc_valid_out(bc_valid_out),
    .collision_mask(collision_mask), .state_we(state_we),
    .pump_amp(pump_amp), .iter_count(iter_count),
    .total_collisions(total_collisions), .busy(busy), .done(done),
    .error(error), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // Monitor / stage responder state
  int n_mvm = 0, n_upd = 0, n_bc = 0, n_we = 0, n_done = 0;
  int done_lat = 0, start_cyc = 0;
  logic err_at_done = 1'b0, ab_at_done = 1'b0, we_prev = 1'b0;
  logic mp = 1'b0, up = 1'b0, bp = 1'b0;
  bit en_mvm = 1'b1, en_upd = 1'b1, en_bc = 1'b1, inj_bc = 1'b0;
  logic [DW-1:0] pump_q[$];

  // Counts strobes and answers each issue with a valid one cycle later.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      done_lat    = cyc - start_cyc;
      err_at_done = error;
      ab_at_done  = aborted;
    end
    if (mvm_start)   n_mvm++;
    if (upd_start)   n_upd++;
    if (bc_valid_in) n_bc++;
    if (state_we)    n_we++;
    if (we_prev) pump_q.push_back(pump_amp);
    we_prev      = state_we;
    mvm_valid    = en_mvm & mp;
    upd_valid    = en_upd & up;
    bc_valid_out = (en_bc & bp) | (inj_bc & mp);
    mp = mvm_start;
    up = upd_start;
    bp = bc_valid_in;
  end

  task automatic clear_mon();
    n_mvm = 0; n_upd = 0; n_bc = 0; n_we = 0; n_done = 0;
    done_lat = -1; err_at_done = 1'b0; ab_at_done = 1'b0;
    pump_q.delete();
  endtask

  task automatic launch(input logic [IW-1:0] n, input logic [DW-1:0] st, input logic [DW-1:0] mx);
    @(negedge clk); #1;
    clear_mon();
    num_iter = n; pump_step = st; pump_max = mx;
    start = 1'b1; start_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (n_done > 0) begin got = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #12;
    checks++; if ({mvm_start, upd_start, bc_valid_in, state_we, busy, done, error, aborted} !== 8'h00)
      $display("FAIL reset_flags: got %b required 00000000", {mvm_start, upd_start, bc_valid_in, state_we, busy, done, error, aborted}); else passes++;
    checks++; if (pump_amp !== '0 || iter_count !== '0 || total_collisions !== '0)
      $display("FAIL reset_counters: pump=%h iter=%h coll=%h required 0", pump_amp, iter_count, total_collisions); else passes++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit got;
    collision_mask = '0;
    launch(3, 32'h4000, 32'(fx_one(16)));
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b required 1", busy); else passes++;
    repeat (3) @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    wait_done(100, got);
    checks++; if (!got) $display("FAIL basic_done_seen: got 0 required 1"); else passes++;
    checks++; if (done_lat !== 22) $display("FAIL basic_latency: got %0d required 22", done_lat); else passes++;
    checks++; if (iter_count !== 16'd3) $display("FAIL basic_iter: got %0d required 3", iter_count); else passes++;
    checks++; if (pump_amp !== 32'hC000) $display("FAIL basic_pump: got %h required c000", pump_amp); else passes++;
    checks++; if ({n_mvm, n_upd, n_bc, n_we} !== {32'd3, 32'd3, 32'd3, 32'd3})
      $display("FAIL basic_pulses: got %0d/%0d/%0d/%0d required 3/3/3/3", n_mvm, n_upd, n_bc, n_we); else passes++;
    checks++; if (err_at_done !== 1'b0 || ab_at_done !== 1'b0)
      $display("FAIL basic_status: err=%b abort=%b required 0/0", err_at_done, ab_at_done); else passes++;
    repeat (3) @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || n_done !== 1 || iter_count !== 16'd3)
      $display("FAIL basic_idle_hold: busy=%b dones=%0d iter=%0d required 0/1/3", busy, n_done, iter_count); else passes++;
  endtask

  task automatic test_saturation();
    bit got;
    logic [DW-1:0] exp_q [5];
    exp_q = '{32'h6000, 32'hC000, 32'h10000, 32'h10000, 32'h10000};
    launch(5, 32'h6000, 32'h10000);
    wait_done(100, got);
    checks++; if (!got || done_lat !== 36) $display("FAIL sat_latency: got %0d required 36", done_lat); else passes++;
    checks++; if (pump_q.size() !== 5) $display("FAIL sat_count: got %0d required 5", pump_q.size()); else passes++;
    for (int i = 0; i < 5 && i < pump_q.size(); i++) begin
      checks++; if (pump_q[i] !== exp_q[i]) $display("FAIL sat_pump_%0d: got %h required %h", i, pump_q[i], exp_q[i]); else passes++;
    end
  endtask

  task automatic test_collisions();
    bit got;
    collision_mask = 8'b1011_0001;
    inj_bc = 1'b1;
    launch(4, 32'h4000, 32'h10000);
    wait_done(100, got);
    inj_bc = 1'b0;
    checks++; if (!got || total_collisions !== 32'd16) $display("FAIL coll_total: got %0d required 16", total_collisions); else passes++;
    checks++; if (iter_count !== 16'd4) $display("FAIL coll_iter: got %0d required 4", iter_count); else passes++;
    collision_mask = '0;
  endtask

  task automatic test_zero_iter();
    bit got;
    launch(0, 32'h4000, 32'h10000);
    @(negedge clk);
    wait_done(10, got);
    checks++; if (!got || done_lat !== 1) $display("FAIL zero_latency: got %0d required 1", done_lat); else passes++;
    checks++; if (n_mvm + n_upd + n_bc + n_we !== 0) $display("FAIL zero_pulses: got %0d required 0", n_mvm + n_upd + n_bc + n_we); else passes++;
    checks++; if (iter_count !== '0 || pump_amp !== '0 || total_collisions !== '0)
      $display("FAIL zero_counters: iter=%0d pump=%h coll=%0d required 0", iter_count, pump_amp, total_collisions); else passes++;
  endtask

  task automatic test_timeout();
    bit got;
    en_mvm = 1'b0;
    launch(2, 32'h4000, 32'h10000);
    wait_done(100, got);
    en_mvm = 1'b1;
    checks++; if (!got || done_lat !== 18) $display("FAIL wd_latency: got %0d required 18", done_lat); else passes++;
    checks++; if (err_at_done !== 1'b1) $display("FAIL wd_error: got %b required 1", err_at_done); else passes++;
    checks++; if (n_mvm !== 1 || n_upd !== 0 || iter_count !== '0)
      $display("FAIL wd_progress: mvm=%0d upd=%0d iter=%0d required 1/0/0", n_mvm, n_upd, iter_count); else passes++;
    repeat (2) @(negedge clk); #1;
    checks++; if (error !== 1'b1) $display("FAIL wd_sticky: got %b required 1", error); else passes++;
    launch(1, 32'h4000, 32'h10000);
    checks++; if (error !== 1'b0) $display("FAIL wd_clear: got %b required 0", error); else passes++;
    wait_done(50, got);
    checks++; if (!got || done_lat !== 8 || iter_count !== 16'd1)
      $display("FAIL wd_recover: lat=%0d iter=%0d required 8/1", done_lat, iter_count); else passes++;
  endtask

  task automatic test_abort();
    bit got, seen;
    launch(2, 32'h4000, 32'h10000);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (upd_valid) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) $display("FAIL abort_setup: got no upd_valid required one"); else passes++;
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done(20, got);
    checks++; if (!got || done_lat !== 5) $display("FAIL abort_latency: got %0d required 5", done_lat); else passes++;
    checks++; if (ab_at_done !== 1'b1) $display("FAIL abort_flag: got %b required 1", ab_at_done); else passes++;
    checks++; if (n_bc !== 0 || n_we !== 0 || n_upd !== 1)
      $display("FAIL abort_pulses: bc=%0d we=%0d upd=%0d required 0/0/1", n_bc, n_we, n_upd); else passes++;
    repeat (2) @(negedge clk); #1;
    clear_mon();
    abort = 1'b1;
    repeat (3) @(negedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || n_done !== 0 || aborted !== 1'b1)
      $display("FAIL abort_idle: busy=%b dones=%0d aborted=%b required 0/0/1", busy, n_done, aborted); else passes++;
    launch(1, 32'h4000, 32'h10000);
    checks++; if (aborted !== 1'b0) $display("FAIL abort_clear: got %b required 0", aborted); else passes++;
    wait_done(50, got);
  endtask

  task automatic test_reset_mid();
    launch(3, 32'h4000, 32'h10000);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mvm_start, upd_start, bc_valid_in, state_we, busy, done, error, aborted} !== 8'h00 ||
                  pump_amp !== '0 || iter_count !== '0 || total_collisions !== '0)
      $display("FAIL rstmid_outputs: flags=%b pump=%h iter=%0d required all 0",
               {mvm_start, upd_start, bc_valid_in, state_we, busy, done, error, aborted}, pump_amp, iter_count); else passes++;
    @(negedge clk); rst_n = 1'b1;
    repeat (30) @(negedge clk); #1;
    checks++; if (n_done !== 0 || busy !== 1'b0) $display("FAIL rstmid_nodone: dones=%0d busy=%b required 0/0", n_done, busy); else passes++;
  endtask

  task automatic test_back_to_back();
    bit got;
    launch(1, 32'h8000, 32'h10000);
    wait_done(50, got);
    checks++; if (!got || done_lat !== 8 || pump_amp !== 32'h8000)
      $display("FAIL b2b_first: lat=%0d pump=%h required 8/8000", done_lat, pump_amp); else passes++;
    launch(2, 32'h3000, 32'h10000);
    wait_done(50, got);
    checks++; if (!got || done_lat !== 15 || pump_amp !== 32'h6000 || iter_count !== 16'd2)
      $display("FAIL b2b_second: lat=%0d pump=%h iter=%0d required 15/6000/2", done_lat, pump_amp, iter_count); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_collisions();
    test_zero_iter();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sb_iteration_controller.md
Name: sb_iteration_controller

Overview:
- Sequences one simulated-bifurcation (SB) time step per iteration across the oscillator datapath, in order: J·x matrix-vector stage, then symplectic x/y update stage, then the wall-collision boundary stage, then state write-back.
- Ramps the pump amplitude a(t) in fixed point, counts iterations, and accumulates the total number of wall collisions.
- Provides a start/done handshake to the host-side configuration logic, plus abort and a per-stage watchdog.

Parameters:
- N, 8, number of oscillators (width of collision_mask).
- DATA_WIDTH, 32, fixed-point word width of pump values.
- FRAC_WIDTH, 16, fractional bits; 1.0 = 2^FRAC_WIDTH.
- ITER_WIDTH, 16, width of iteration count/config.
- CNT_WIDTH, 32, width of collision accumulator.
- TIMEOUT_CYCLES, 1024, maximum cycles any WAIT state may last before error.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin run; accepted only in IDLE
- abort  in  1  terminate run at next cycle
- num_iter  in  ITER_WIDTH  iterations to run; sampled at start acceptance
- pump_step  in  DATA_WIDTH  unsigned a(t) increment per iteration; sampled at start acceptance
- pump_max  in  DATA_WIDTH  unsigned a(t) saturation value (normally 1.0); sampled at start acceptance
- mvm_start  out  1  one-cycle pulse launching J·x
- mvm_valid  in  1  J·x result ready
- upd_start  out  1  one-cycle pulse launching x/y update
- upd_valid  in  1  update result ready
- bc_valid_in  out  1  one-cycle pulse into the boundary stage
- bc_valid_out  in  1  boundary stage result valid
- collision_mask  in  N  per-oscillator collision flags, qualified by bc_valid_out
- state_we  out  1  one-cycle write-back strobe for enforced x/y
- pump_amp  out  DATA_WIDTH  current a(t)
- iter_count  out  ITER_WIDTH  completed iterations
- total_collisions  out  CNT_WIDTH  saturating sum of collisions this run
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at run end
- error  out  1  watchdog fired; sticky until next start accepted
- aborted  out  1  run ended by abort; sticky until next start accepted

Behaviour:
- Reset: state = IDLE; every output is 0.
- States: IDLE, MVM_ISSUE, MVM_WAIT, UPD_ISSUE, UPD_WAIT, BC_ISSUE, BC_WAIT, STEP, DONE.
- Outputs are Moore-decoded:
  - mvm_start = MVM_ISSUE
  - upd_start = UPD_ISSUE
  - bc_valid_in = BC_ISSUE
  - state_we = STEP
  - done = DONE
- IDLE + start:
  - Capture num_iter, pump_step and pump_max.
  - Clear pump_amp, iter_count, total_collisions, error and aborted.
  - Next state is MVM_ISSUE, or DONE if num_iter == 0.
- ISSUE states always advance to their WAIT state after one cycle.
- WAIT states:
  - Advance when their own valid is high: MVM_WAIT→UPD_ISSUE, UPD_WAIT→BC_ISSUE, BC_WAIT→STEP.
  - The valid is sampled only in the matching WAIT state; valids in any other state are ignored.
- BC_WAIT with bc_valid_out: total_collisions += popcount(collision_mask), saturating at 2^CNT_WIDTH−1.
- STEP:
  - iter_count += 1.
  - pump_amp = min(pump_amp + pump_step, pump_max), computed unsigned with a carry bit so overflow saturates to pump_max.
  - Next state is DONE if iter_count+1 == num_iter, else MVM_ISSUE.
- DONE: done = 1 for exactly one cycle, then IDLE. busy = 0 only in IDLE.
- Minimum iteration time is 7 cycles (each valid returns the cycle after its issue). With start sampled at cycle 0, done is high at cycle 1 + 7·num_iter.
- Watchdog:
  - A per-WAIT cycle counter clears on WAIT entry.
  - If the counter reaches TIMEOUT_CYCLES−1 without the expected valid, set error = 1 and go to DONE.
- Abort:
  - In any state other than IDLE and DONE, abort = 1 forces DONE next cycle and sets aborted = 1.
  - Abort has priority over a simultaneous valid or timeout; that valid's collisions are not counted.
  - Abort in IDLE or DONE is ignored.
- start while busy is ignored.
- Asynchronous reset mid-run returns to IDLE with all outputs 0. No done pulse is generated.
- iter_count, pump_amp and total_collisions hold their final values in IDLE until the next start.

Decomposition:
- Package sb_ctrl_pkg holds:
  - the state enum type
  - a fixed-point ONE(FRAC_WIDTH) constant function
  - a saturating unsigned add function
- One sub-module, sb_popcount, parameterised on N: a combinational count of collision_mask bits with output width $clog2(N+1).

Test Plan:
- num_iter=3, pump_step=0x4000, pump_max=0x10000, every valid returned 1 cycle after its issue -> done at cycle 22, iter_count=3, pump_amp=0xC000, exactly 3 pulses each of mvm_start/upd_start/bc_valid_in/state_we.
- num_iter=5, pump_step=0x6000, pump_max=0x10000 -> pump_amp sequence 0x6000, 0xC000, 0x10000, 0x10000, 0x10000 (saturation).
- collision_mask=8'b1011_0001 on every bc_valid_out, num_iter=4 -> total_collisions=16; a bc_valid_out injected during MVM_WAIT is not counted.
- num_iter=0 -> done 1 cycle after start, no stage pulses, iter_count=0.
- mvm_valid withheld, TIMEOUT_CYCLES=16 -> error=1 and done pulse 16 cycles after MVM_WAIT entry; error clears on next accepted start.
- abort asserted in UPD_WAIT on the same cycle as upd_valid -> DONE next cycle, aborted=1, no bc_valid_in; rst_n pulse mid-run -> all outputs 0, no done.
